// File: rtl/game_fsm_if.sv
// Signal bundle between the screen sequencer and its keypad / game-logic neighbours.
// The sequencer connects through the slave modport.
interface game_fsm_if;
  logic       keypad_pressed;
  logic [4:0] key;
  logic       game_over;
  logic       player_won;
  logic [2:0] presente;
  logic       win;
  logic       game_start;
  logic       screen_enter;

  modport master (
    output keypad_pressed, key, game_over, player_won,
    input  presente, win, game_start, screen_enter
  );

  modport slave (
    input  keypad_pressed, key, game_over, player_won,
    output presente, win, game_start, screen_enter
  );
endinterface

// File: rtl/game_fsm.sv
// Top-level screen sequencer: drives the presente screen code from key presses,
// dwell timers and the game-over flag, and strobes screen entry / game start.
//
// state | meaning
// OFF   | console off, waiting for POWER
// WLCM  | welcome screen, timed dwell
// CH    | hero chooser
// GAME  | game running
// WL    | win/lose screen, timed dwell
// PA    | game paused
module game_fsm #(
  parameter int WLCM_CYCLES = 100_000_000,
  parameter int WL_CYCLES   = 150_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst,
  game_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF  = 3'd0,
    S_WLCM = 3'd1,
    S_CH   = 3'd2,
    S_GAME = 3'd3,
    S_WL   = 3'd4,
    S_PA   = 3'd5
  } state_t;

  localparam logic [4:0] KEY_POWER = 5'd10;
  localparam logic [4:0] KEY_OK    = 5'd5;
  localparam logic [4:0] KEY_PAUSE = 5'd11;

  localparam logic [CNT_W-1:0] WLCM_LAST = CNT_W'(WLCM_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LAST   = CNT_W'(WL_CYCLES - 1);

  logic [2:0]       state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;
  logic             win_q;
  logic             start_q;
  logic             enter_q;
  logic             start_d;
  logic             win_ld;
  logic             accept;
  logic             pwr;
  logic             ok;
  logic             pause;
  logic             expire;
  logic             dwelling;

  // One accepted press per physical press: armed only after a released cycle.
  assign accept = bus.keypad_pressed & armed_q;
  assign pwr    = accept && (bus.key == KEY_POWER);
  assign ok     = accept && (bus.key == KEY_OK);
  assign pause  = accept && (bus.key == KEY_PAUSE);

  assign dwelling = (state_q == S_WLCM) || (state_q == S_WL);
  assign expire   = ((state_q == S_WLCM) && (cnt_q == WLCM_LAST)) ||
                    ((state_q == S_WL)   && (cnt_q == WL_LAST));

  always_comb begin
    state_d = state_t'(state_q);
    start_d = 1'b0;
    win_ld  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (pwr) state_d = S_WLCM;
      end
      S_WLCM: begin
        if (pwr)               state_d = S_OFF;
        else if (ok || expire) state_d = S_CH;
      end
      S_CH: begin
        if (pwr) state_d = S_OFF;
        else if (ok) begin
          state_d = S_GAME;
          start_d = 1'b1;
        end
      end
      S_GAME: begin
        if (pwr) state_d = S_OFF;
        else if (bus.game_over) begin
          state_d = S_WL;
          win_ld  = 1'b1;
        end
        else if (pause) state_d = S_PA;
      end
      S_PA: begin
        if (pwr)        state_d = S_OFF;
        else if (pause) state_d = S_GAME;
      end
      S_WL: begin
        if (pwr)         state_d = S_OFF;
        else if (ok)     state_d = S_CH;
        else if (expire) state_d = S_WLCM;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      win_q   <= 1'b0;
      start_q <= 1'b0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= (state_d != state_q);
      start_q <= start_d;
      armed_q <= ~bus.keypad_pressed;
      if (win_ld) win_q <= bus.player_won;
      if ((state_d != state_q) || !dwelling) cnt_q <= '0;
      else                                   cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.presente     = state_q;
  assign bus.win          = win_q;
  assign bus.game_start   = start_q;
  assign bus.screen_enter = enter_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: a screen-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_game_fsm;
  localparam int WLCM_N = 4;
  localparam int WL_N   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b1;

  game_fsm_if bus_i ();

  game_fsm #(.WLCM_CYCLES(WLCM_N), .WL_CYCLES(WL_N), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Screen-level model: remaining dwell cycles instead of a count-up timer.
  int m_scr   = 0;
  int m_left  = 0;
  bit m_win   = 0;
  bit m_start = 0;
  bit m_enter = 0;
  bit m_ready = 0;

  always @(posedge clk) begin
    int  nxt;
    bit  acc;
    bit  st;
    if (rst) begin
      m_scr = 0; m_left = 0; m_win = 0; m_start = 0; m_enter = 0; m_ready = 0;
    end else begin
      acc = bus_i.keypad_pressed && m_ready;
      m_ready = !bus_i.keypad_pressed;
      nxt = m_scr;
      st  = 0;
      if (m_scr > 5) nxt = 0;
      else if (acc && bus_i.key == 5'd10) nxt = (m_scr == 0) ? 1 : 0;
      else if (m_scr == 3 && bus_i.game_over) begin
        nxt = 4;
        m_win = bus_i.player_won;
      end
      else if (acc && bus_i.key == 5'd5 && (m_scr == 1 || m_scr == 2 || m_scr == 4)) begin
        nxt = (m_scr == 2) ? 3 : 2;
        st  = (m_scr == 2);
      end
      else if (acc && bus_i.key == 5'd11 && (m_scr == 3 || m_scr == 5))
        nxt = (m_scr == 3) ? 5 : 3;
      else if (m_scr == 1 && m_left == 1) nxt = 2;
      else if (m_scr == 4 && m_left == 1) nxt = 1;
      m_enter = (nxt != m_scr);
      m_start = st;
      if (nxt != m_scr) m_left = (nxt == 1) ? WLCM_N : (nxt == 4) ? WL_N : 0;
      else if (m_left > 0) m_left--;
      m_scr = nxt;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("model presente",     int'(bus_i.presente),     m_scr);
      chk("model win",          int'(bus_i.win),          int'(m_win));
      chk("model game_start",   int'(bus_i.game_start),   int'(m_start));
      chk("model screen_enter", int'(bus_i.screen_enter), int'(m_enter));
    end
  end

  task automatic press(input logic [4:0] k);
    bus_i.keypad_pressed = 1'b0;
    @(negedge clk);
    bus_i.keypad_pressed = 1'b1;
    bus_i.key = k;
    @(negedge clk);
    bus_i.keypad_pressed = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int trans;
    int gs;
    int prev;
    bus_i.keypad_pressed = 1'b0;
    bus_i.key = 5'd0;
    bus_i.game_over = 1'b0;
    bus_i.player_won = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset presente", int'(bus_i.presente), 0);
    chk("reset win", int'(bus_i.win), 0);
    chk("reset screen_enter", int'(bus_i.screen_enter), 0);
    chk("reset game_start", int'(bus_i.game_start), 0);
    rst = 1'b0;

    // Power-up and welcome dwell
    press(5'd10);
    chk("power-up presente", int'(bus_i.presente), 1);
    chk("power-up screen_enter", int'(bus_i.screen_enter), 1);
    repeat (3) @(negedge clk);
    chk("wlcm 4th cycle presente", int'(bus_i.presente), 1);
    chk("wlcm 4th cycle screen_enter", int'(bus_i.screen_enter), 0);
    @(negedge clk);
    chk("wlcm expiry presente", int'(bus_i.presente), 2);
    chk("wlcm expiry screen_enter", int'(bus_i.screen_enter), 1);

    // Held OK for 10 cycles in CH
    trans = 0; gs = 0; prev = int'(bus_i.presente);
    bus_i.keypad_pressed = 1'b1;
    bus_i.key = 5'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(bus_i.presente) != prev) trans++;
      if (bus_i.game_start) gs++;
      prev = int'(bus_i.presente);
    end
    bus_i.keypad_pressed = 1'b0;
    chk("held ok transitions", trans, 1);
    chk("held ok game_start pulses", gs, 1);
    chk("held ok presente", int'(bus_i.presente), 3);

    // Pause and resume
    press(5'd11);
    chk("pause presente", int'(bus_i.presente), 5);
    chk("pause screen_enter", int'(bus_i.screen_enter), 1);
    press(5'd11);
    chk("resume presente", int'(bus_i.presente), 3);
    chk("resume screen_enter", int'(bus_i.screen_enter), 1);
    chk("resume game_start", int'(bus_i.game_start), 0);

    // Win with simultaneous pause press
    @(negedge clk);
    bus_i.game_over = 1'b1;
    bus_i.player_won = 1'b1;
    bus_i.keypad_pressed = 1'b1;
    bus_i.key = 5'd11;
    @(negedge clk);
    bus_i.game_over = 1'b0;
    bus_i.keypad_pressed = 1'b0;
    chk("game end presente", int'(bus_i.presente), 4);
    chk("game end win", int'(bus_i.win), 1);
    repeat (2) @(negedge clk);
    chk("wl 3rd cycle presente", int'(bus_i.presente), 4);
    @(negedge clk);
    chk("wl expiry presente", int'(bus_i.presente), 1);
    chk("wl expiry win held", int'(bus_i.win), 1);

    // OK skips welcome; lose; OK leaves WL
    press(5'd5);
    chk("ok in wlcm presente", int'(bus_i.presente), 2);
    press(5'd5);
    chk("second game_start", int'(bus_i.game_start), 1);
    @(negedge clk);
    bus_i.game_over = 1'b1;
    bus_i.player_won = 1'b0;
    @(negedge clk);
    bus_i.game_over = 1'b0;
    chk("lose presente", int'(bus_i.presente), 4);
    chk("lose win", int'(bus_i.win), 0);
    press(5'd5);
    chk("ok in wl presente", int'(bus_i.presente), 2);
    press(5'd5);
    press(5'd11);
    chk("paused again presente", int'(bus_i.presente), 5);

    // POWER beats game_over in PA
    @(negedge clk);
    bus_i.game_over = 1'b1;
    bus_i.keypad_pressed = 1'b1;
    bus_i.key = 5'd10;
    @(negedge clk);
    bus_i.game_over = 1'b0;
    bus_i.keypad_pressed = 1'b0;
    chk("power-off presente", int'(bus_i.presente), 0);

    // Key held through reset is not accepted until re-pressed
    @(negedge clk);
    rst = 1'b1;
    bus_i.keypad_pressed = 1'b1;
    bus_i.key = 5'd10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held through reset presente", int'(bus_i.presente), 0);
    bus_i.keypad_pressed = 1'b0;
    @(negedge clk);
    bus_i.keypad_pressed = 1'b1;
    @(negedge clk);
    bus_i.keypad_pressed = 1'b0;
    chk("re-press after reset presente", int'(bus_i.presente), 1);
    press(5'd10);
    chk("power-off from wlcm presente", int'(bus_i.presente), 0);

    // Illegal state code recovers to OFF
    @(negedge clk);
    chk_en = 1'b0;
    force dut.state_q = 3'd6;
    @(negedge clk);
    chk("illegal screen_enter", int'(bus_i.screen_enter), 1);
    release dut.state_q;
    @(negedge clk);
    chk("illegal recovery presente", int'(bus_i.presente), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
